// File: rtl/jram_arbiter.sv
// jram_arbiter: shares one jRAM between two word requesters (req0 = CPU,
// req1 = loader/IO) and sequences each request into the jRAM strobe protocol:
// MAR load (ram_bas/ram_wsa), then either a write (ram_bio driven, ram_ws
// pulse) or a read (ram_we pulse, ram_bio sampled). Completions come back on
// one response channel tagged with the requester id.
//
// Configuration macro: JRAM_ARB_RR_EN
//   defined   -> round-robin between simultaneous requesters (rr_last tracks
//                the last winner; reset value 1 so req0 wins first)
//   undefined -> fixed priority, req0 always wins
//
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   reqN_valid/ready          request handshake (N = 0, 1); ready is combinational
//   reqN_wr/addr/wdata        request payload (1 = write)
//   rsp_valid/rsp_id          one-cycle completion pulse and owning requester
//   rsp_rdata                 read data; 0 after a write; holds otherwise
//   ram_bas, ram_wsa          jRAM address bus and address strobe
//   ram_bio                   jRAM bidirectional data bus (driven only while writing)
//   ram_ws, ram_we            jRAM write strobe and read enable

`ifndef ARCH_BITS
`define ARCH_BITS 8
`endif

module jram_arbiter #(
  parameter int unsigned W             = `ARCH_BITS,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_wr,
  input  logic [W-1:0] req0_addr,
  input  logic [W-1:0] req0_wdata,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_wr,
  input  logic [W-1:0] req1_addr,
  input  logic [W-1:0] req1_wdata,

  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_rdata,

  output logic [W-1:0] ram_bas,
  output logic         ram_wsa,
  inout  wire  [W-1:0] ram_bio,
  output logic         ram_ws,
  output logic         ram_we
);

  localparam logic [3:0] STROBE_M1 = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, AHOLD, WSETUP, WSTRB, WHOLD, RSTRB, DONE
  } state_t;

  state_t         state, state_d;
  logic [3:0]     cnt, cnt_d;

  logic           accept;
  logic           rdata_cap, rdata_clr;
  logic           wsa_d, ws_d, we_d, bio_oe_d, rsp_valid_d;

  logic           bio_oe;
  logic           wr_q;
  logic           id_q;
  logic [W-1:0]   wdata_q;

  logic           grant_any;
  logic           grant_id;
  logic           grant_wr;
  logic [W-1:0]   grant_addr;
  logic [W-1:0]   grant_wdata;

`ifdef JRAM_ARB_RR_EN
  logic           rr_last;
`endif

  // Arbitration among valid requesters
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
`ifdef JRAM_ARB_RR_EN
    if (req0_valid && req1_valid) grant_id = ~rr_last;
    else                          grant_id = req1_valid;
`else
    grant_id  = ~req0_valid & req1_valid;
`endif
    grant_wr    = grant_id ? req1_wr    : req0_wr;
    grant_addr  = grant_id ? req1_addr  : req0_addr;
    grant_wdata = grant_id ? req1_wdata : req0_wdata;
  end

  assign req0_ready = (state == IDLE) & req0_valid & ~grant_id;
  assign req1_ready = (state == IDLE) & req1_valid &  grant_id;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic and next values of the registered strobes
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    rdata_cap = 1'b0;
    rdata_clr = 1'b0;

    case (state)
      IDLE: begin
        if (grant_any) begin
          accept  = 1'b1;
          state_d = ADDR;
          cnt_d   = STROBE_M1;
        end
      end
      ADDR: begin
        if (cnt == 4'd0) state_d = AHOLD;
        else             cnt_d   = cnt - 4'd1;
      end
      AHOLD: begin
        if (wr_q) begin
          state_d = WSETUP;
        end else begin
          state_d = RSTRB;
          cnt_d   = STROBE_M1;
        end
      end
      WSETUP: begin
        state_d = WSTRB;
        cnt_d   = STROBE_M1;
      end
      WSTRB: begin
        if (cnt == 4'd0) state_d = WHOLD;
        else             cnt_d   = cnt - 4'd1;
      end
      WHOLD: begin
        state_d   = DONE;
        rdata_clr = 1'b1;
      end
      RSTRB: begin
        if (cnt == 4'd0) begin
          state_d   = DONE;
          rdata_cap = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they align with the state
    wsa_d       = (state_d == ADDR);
    ws_d        = (state_d == WSTRB);
    we_d        = (state_d == RSTRB);
    bio_oe_d    = (state_d == WSETUP) || (state_d == WSTRB) || (state_d == WHOLD);
    rsp_valid_d = (state_d == DONE);
  end

  // Registered outputs and request payload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_wsa   <= 1'b0;
      ram_ws    <= 1'b0;
      ram_we    <= 1'b0;
      bio_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= '0;
      ram_bas   <= '0;
      wr_q      <= 1'b0;
      id_q      <= 1'b0;
      wdata_q   <= '0;
`ifdef JRAM_ARB_RR_EN
      rr_last   <= 1'b1;
`endif
    end else begin
      ram_wsa   <= wsa_d;
      ram_ws    <= ws_d;
      ram_we    <= we_d;
      bio_oe    <= bio_oe_d;
      rsp_valid <= rsp_valid_d;
      if (accept) begin
        wr_q    <= grant_wr;
        id_q    <= grant_id;
        wdata_q <= grant_wdata;
        ram_bas <= grant_addr;
`ifdef JRAM_ARB_RR_EN
        rr_last <= grant_id;
`endif
      end
      if (rdata_cap)      rsp_rdata <= ram_bio;
      else if (rdata_clr) rsp_rdata <= '0;
      if (rsp_valid_d)    rsp_id    <= id_q;
    end
  end

  // Data bus driven only in write states; released otherwise
  assign ram_bio = bio_oe ? wdata_q : {W{1'bz}};

endmodule

// File: tb/tb_jram_arbiter.sv
// Directed testbench for jram_arbiter with a small jRAM model on the data bus.
// Released bus lines are pulled up, so an undriven ram_bio reads as all ones.
`timescale 1ns/1ps

module tb_jram_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       req0_valid = 1'b0, req0_wr = 1'b0;
  logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
  logic       req1_valid = 1'b0, req1_wr = 1'b0;
  logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id;
  logic [7:0] rsp_rdata, ram_bas;
  logic       ram_wsa, ram_ws, ram_we;
  wire  [7:0] ram_bio;

  // second instance with STROBE_CYCLES = 3, write-only shape check
  logic       d3_valid = 1'b0;
  logic [7:0] d3_addr = 8'h00, d3_wdata = 8'h00;
  logic       d3_ready, d3_ready1, d3_rsp_valid, d3_rsp_id;
  logic [7:0] d3_rdata, d3_bas;
  logic       d3_wsa, d3_ws, d3_we;
  wire  [7:0] d3_bio;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (ram_bio[i]);
    pullup (d3_bio[i]);
  end

  jram_arbiter #(.W(8), .STROBE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .ram_bas(ram_bas), .ram_wsa(ram_wsa), .ram_bio(ram_bio),
    .ram_ws(ram_ws), .ram_we(ram_we)
  );

  jram_arbiter #(.W(8), .STROBE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(d3_valid), .req0_ready(d3_ready), .req0_wr(1'b1),
    .req0_addr(d3_addr), .req0_wdata(d3_wdata),
    .req1_valid(1'b0), .req1_ready(d3_ready1), .req1_wr(1'b0),
    .req1_addr(8'h00), .req1_wdata(8'h00),
    .rsp_valid(d3_rsp_valid), .rsp_id(d3_rsp_id), .rsp_rdata(d3_rdata),
    .ram_bas(d3_bas), .ram_wsa(d3_wsa), .ram_bio(d3_bio),
    .ram_ws(d3_ws), .ram_we(d3_we)
  );

  // jRAM model: MAR loads on wsa, write on ws, drives bio while we
  logic [7:0] mem [256];
  logic [7:0] mar = 8'h00;
  always @(posedge clk) begin
    if (ram_wsa) mar <= ram_bas;
    if (ram_ws)  mem[mar] <= ram_bio;
  end
  assign ram_bio = ram_we ? mem[mar] : 8'hzz;

  // Bus monitor over the whole run
  always @(negedge clk) begin
    if (!reset && (ram_wsa || ram_ws || ram_we)) begin
      checks++;
      if ((32'(ram_wsa) + 32'(ram_ws) + 32'(ram_we)) > 1) begin
        failures++;
        $display("FAIL bus_strobes: wsa=%b ws=%b we=%b, required at most one high", ram_wsa, ram_ws, ram_we);
      end else if (ram_we && ram_bio !== mem[mar]) begin
        failures++;
        $display("FAIL bus_read_contention: bio=%h, required %h", ram_bio, mem[mar]);
      end else if (ram_wsa && ram_bio !== 8'hFF) begin
        failures++;
        $display("FAIL bus_addr_drive: bio=%h during wsa, required released", ram_bio);
      end
    end
    if (!reset && (d3_wsa || d3_ws || d3_we)) begin
      checks++;
      if ((32'(d3_wsa) + 32'(d3_ws) + 32'(d3_we)) > 1) begin
        failures++;
        $display("FAIL bus3_strobes: wsa=%b ws=%b we=%b, required at most one high", d3_wsa, d3_ws, d3_we);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Single transaction on dut; reports latency from handshake edge to rsp cycle
  task automatic do_txn(input logic id, input logic wr, input logic [7:0] addr,
                        input logic [7:0] data, output int lat, output logic rid,
                        output logic [7:0] rdata, output logic ok);
    logic got;
    ok = 1'b0; lat = 0; rid = 1'b0; rdata = 8'h00; got = 1'b0;
    @(negedge clk);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_wr = wr; req0_addr = addr; req0_wdata = data;
    end else begin
      req1_valid = 1'b1; req1_wr = wr; req1_addr = addr; req1_wdata = data;
    end
    for (int n = 0; n < 20; n++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!got) return;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = n; rid = rsp_id; rdata = rsp_rdata; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, ram_wsa, ram_ws, ram_we} !== 5'b0 || rsp_rdata !== 8'h00 || ram_bas !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: rsp_valid=%b rsp_id=%b wsa=%b ws=%b we=%b rdata=%h bas=%h, required all 0",
               rsp_valid, rsp_id, ram_wsa, ram_ws, ram_we, rsp_rdata, ram_bas);
    end
    checks++;
    if (ram_bio !== 8'hFF) begin
      failures++;
      $display("FAIL reset_bio: bio=%h, required released (ff)", ram_bio);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready_novalid: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready0: ready0=%b, required 1", req0_ready);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic rid; logic [7:0] rd; logic ok;
    do_txn(1'b0, 1'b1, 8'h12, 8'hA5, lat, rid, rd, ok);
    checks++;
    if (!ok || lat != 6 || rid !== 1'b0 || rd !== 8'h00) begin
      failures++;
      $display("FAIL write_rsp: ok=%b lat=%0d id=%b rdata=%h, required ok=1 lat=6 id=0 rdata=00", ok, lat, rid, rd);
    end
    checks++;
    if (ram_bas !== 8'h12) begin
      failures++;
      $display("FAIL write_bas: bas=%h, required 12", ram_bas);
    end
    do_txn(1'b0, 1'b0, 8'h12, 8'h00, lat, rid, rd, ok);
    checks++;
    if (!ok || lat != 4 || rid !== 1'b0 || rd !== 8'hA5) begin
      failures++;
      $display("FAIL read_rsp: ok=%b lat=%0d id=%b rdata=%h, required ok=1 lat=4 id=0 rdata=a5", ok, lat, rid, rd);
    end
  endtask

  task automatic test_strobe_shape();
    logic [11:0] got, exp;
    @(negedge clk);
    d3_valid = 1'b1; d3_addr = 8'h40; d3_wdata = 8'h5A;
    #1;
    checks++;
    if (d3_ready !== 1'b1) begin
      failures++;
      $display("FAIL shape_ready: ready=%b, required 1", d3_ready);
    end
    @(posedge clk);
    #1;
    d3_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      got = {d3_wsa, d3_ws, d3_we, d3_rsp_valid, d3_bio};
      exp = {(k >= 1 && k <= 3), (k >= 6 && k <= 8), 1'b0, (k == 10),
             ((k >= 5 && k <= 9) ? 8'h5A : 8'hFF)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL shape_cycle%0d: {wsa,ws,we,rsp,bio}=%h, required %h", k, got, exp);
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] ids, exp_ids;
    int seen;
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 8'h12;
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 8'h20;
    ids = 4'h0; seen = 0;
    for (int n = 0; n < 60 && seen < 4; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ids[seen] = rsp_id;
        seen++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
`ifdef JRAM_ARB_RR_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    checks++;
    if (seen != 4 || ids !== exp_ids) begin
      failures++;
      $display("FAIL contention_grants: seen=%0d ids(lsb first)=%b, required 4 and %b", seen, ids, exp_ids);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_isolation();
    int lat; logic rid; logic [7:0] rd; logic ok;
    do_txn(1'b1, 1'b1, 8'hFF, 8'h3C, lat, rid, rd, ok);
    checks++;
    if (!ok || lat != 6 || rid !== 1'b1) begin
      failures++;
      $display("FAIL iso_wr1: ok=%b lat=%0d id=%b, required ok=1 lat=6 id=1", ok, lat, rid);
    end
    do_txn(1'b0, 1'b1, 8'h00, 8'h5A, lat, rid, rd, ok);
    checks++;
    if (!ok || rid !== 1'b0 || rd !== 8'h00) begin
      failures++;
      $display("FAIL iso_wr0: ok=%b id=%b rdata=%h, required ok=1 id=0 rdata=00", ok, rid, rd);
    end
    do_txn(1'b1, 1'b0, 8'hFF, 8'h00, lat, rid, rd, ok);
    checks++;
    if (!ok || lat != 4 || rid !== 1'b1 || rd !== 8'h3C) begin
      failures++;
      $display("FAIL iso_rd1: ok=%b lat=%0d id=%b rdata=%h, required ok=1 lat=4 id=1 rdata=3c", ok, lat, rid, rd);
    end
    do_txn(1'b0, 1'b0, 8'h00, 8'h00, lat, rid, rd, ok);
    checks++;
    if (!ok || rid !== 1'b0 || rd !== 8'h5A) begin
      failures++;
      $display("FAIL iso_rd0: ok=%b id=%b rdata=%h, required ok=1 id=0 rdata=5a", ok, rid, rd);
    end
  endtask

  task automatic test_reset_mid_read();
    int lat; logic rid; logic [7:0] rd; logic ok;
    logic saw_we, saw_rsp;
    @(negedge clk);
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 8'h12;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready: ready0=%b, required 1", req0_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    saw_we = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        saw_we = 1'b1;
        break;
      end
    end
    checks++;
    if (saw_we !== 1'b1) begin
      failures++;
      $display("FAIL midrst_we_seen: we never rose within 10 cycles, required high in RSTRB");
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ram_wsa, ram_ws, ram_we, rsp_valid} !== 4'b0 || ram_bio !== 8'hFF) begin
      failures++;
      $display("FAIL midrst_drop: wsa=%b ws=%b we=%b rsp=%b bio=%h, required 0 0 0 0 ff",
               ram_wsa, ram_ws, ram_we, rsp_valid, ram_bio);
    end
    saw_rsp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) saw_rsp = 1'b1;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_rsp: rsp_valid seen=%b, required 0", saw_rsp);
    end
    do_txn(1'b0, 1'b0, 8'h12, 8'h00, lat, rid, rd, ok);
    checks++;
    if (!ok || lat != 4 || rid !== 1'b0 || rd !== 8'hA5) begin
      failures++;
      $display("FAIL midrst_recover: ok=%b lat=%0d id=%b rdata=%h, required ok=1 lat=4 id=0 rdata=a5", ok, lat, rid, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe_shape();
    test_contention();
    test_isolation();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
